// File: rtl/adc_decimator.sv
// adc_decimator: power-of-two averaging / keep-last decimator after the ADC FIR.
// Ports: clock, reset (async, high), pipeline_flush, cfg_we/cfg_ratio_log2/
// cfg_average, in_valid/in_ready/data_in, out_valid/out_ready/data_out.
module adc_decimator #(
  parameter int DATA_PATH_WIDTH = 16,
  parameter int MAX_RATIO_LOG2  = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              pipeline_flush,
  input  logic                              cfg_we,
  input  logic [2:0]                        cfg_ratio_log2,
  input  logic                              cfg_average,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_PATH_WIDTH-1:0] data_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [DATA_PATH_WIDTH-1:0] data_out
);

  localparam int W  = DATA_PATH_WIDTH;
  localparam int AW = DATA_PATH_WIDTH + MAX_RATIO_LOG2;
  localparam int CW = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1;
  localparam logic [2:0] RMAX = 3'(MAX_RATIO_LOG2);

  logic signed [AW-1:0] acc;
  logic [CW-1:0]        count;
  logic [2:0]           ratio_log2;
  logic                 average;

  logic signed [AW-1:0] din_ext;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] acc_shift;
  logic [CW-1:0]        last_cnt;
  logic [2:0]           ratio_clamped;
  logic                 accept;
  logic                 complete;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign din_ext   = {{MAX_RATIO_LOG2{data_in[W-1]}}, data_in};
  assign acc_next  = (count == '0) ? din_ext : acc + din_ext;
  assign acc_shift = acc_next >>> ratio_log2;

  // N-1 as a mask of ratio_log2 low ones
  assign last_cnt = ~({CW{1'b1}} << ratio_log2);

  // A config write in the same cycle discards the input
  assign complete = accept & ~cfg_we & (count == last_cnt);

  assign ratio_clamped =
    (cfg_ratio_log2 > RMAX) ? RMAX : cfg_ratio_log2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      ratio_log2 <= '0;
      average    <= 1'b1;
      out_valid  <= 1'b0;
      data_out   <= '0;
    end else if (pipeline_flush) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      if (cfg_we) begin
        ratio_log2 <= ratio_clamped;
        average    <= cfg_average;
        count      <= '0;
      end else if (accept) begin
        acc <= acc_next;
        if (complete) begin
          count    <= '0;
          data_out <= average ? acc_shift[W-1:0] : data_in;
        end else begin
          count <= count + 1'b1;
        end
      end

      if (complete)
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_decimator.sv
// tb_adc_decimator: directed-vector bench for adc_decimator.
// Inputs change on the falling edge; outputs are sampled 1 ns after rising edges.
module tb_adc_decimator;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               pipeline_flush = 1'b0;
  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_ratio_log2 = '0;
  logic               cfg_average = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] data_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] data_out;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  adc_decimator #(
    .DATA_PATH_WIDTH(16),
    .MAX_RATIO_LOG2(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pipeline_flush(pipeline_flush),
    .cfg_we(cfg_we),
    .cfg_ratio_log2(cfg_ratio_log2),
    .cfg_average(cfg_average),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out)
  );

  task automatic send(input logic signed [15:0] d);
    @(negedge clock);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] r, input logic avg);
    @(negedge clock);
    cfg_we         = 1'b1;
    cfg_ratio_log2 = r;
    cfg_average    = avg;
    @(posedge clock);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (data_out !== 16'sd0) begin
      failures++;
      $display("FAIL reset_data_out: got %0d expected 0", data_out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_average();
    cfg(3'd2, 1'b1);
    out_ready = 1'b1;
    send(16'sd4);
    send(16'sd8);
    send(16'sd12);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL avg_early_valid: got %b expected 0", out_valid);
    end
    send(16'sd16);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd10) begin
      failures++;
      $display("FAIL avg_result: got v=%b d=%0d expected v=1 d=10",
               out_valid, data_out);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL avg_one_cycle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_negative();
    cfg(3'd1, 1'b1);
    send(-16'sd3);
    send(-16'sd4);
    checks++;
    if (out_valid !== 1'b1 || data_out !== -16'sd4) begin
      failures++;
      $display("FAIL avg_neg_floor: got v=%b d=%0d expected v=1 d=-4",
               out_valid, data_out);
    end
    send(16'sd32767);
    send(16'sd32767);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd32767) begin
      failures++;
      $display("FAIL avg_max: got v=%b d=%0d expected v=1 d=32767",
               out_valid, data_out);
    end
  endtask

  task automatic test_decimate();
    cfg(3'd2, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      send(16'(i));
      if (i == 4) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'sd4) begin
          failures++;
          $display("FAIL dec_first: got v=%b d=%0d expected v=1 d=4",
                   out_valid, data_out);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd8) begin
      failures++;
      $display("FAIL dec_second: got v=%b d=%0d expected v=1 d=8",
               out_valid, data_out);
    end
  endtask

  task automatic test_backpressure();
    cfg(3'd0, 1'b1);
    out_ready = 1'b0;
    send(16'sd5);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd5) begin
      failures++;
      $display("FAIL bp_first: got v=%b d=%0d expected v=1 d=5",
               out_valid, data_out);
    end
    @(negedge clock);
    in_valid = 1'b1;
    data_in  = 16'sd6;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready: got %b expected 0", in_ready);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd5) begin
      failures++;
      $display("FAIL bp_hold: got v=%b d=%0d expected v=1 d=5",
               out_valid, data_out);
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd6) begin
      failures++;
      $display("FAIL bp_drain_load: got v=%b d=%0d expected v=1 d=6",
               out_valid, data_out);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_cfg_midblock();
    cfg(3'd2, 1'b1);
    send(16'sd100);
    send(16'sd200);
    cfg(3'd1, 1'b1);
    send(16'sd6);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL cfg_mid_early: got %b expected 0", out_valid);
    end
    send(16'sd10);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd8) begin
      failures++;
      $display("FAIL cfg_mid_result: got v=%b d=%0d expected v=1 d=8",
               out_valid, data_out);
    end
  endtask

  task automatic test_flush();
    cfg(3'd2, 1'b1);
    send(16'sd1);
    send(16'sd2);
    send(16'sd3);
    @(negedge clock);
    pipeline_flush = 1'b1;
    @(posedge clock);
    #1;
    pipeline_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid: got %b expected 0", out_valid);
    end
    send(16'sd4);
    send(16'sd8);
    send(16'sd12);
    send(16'sd16);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd10) begin
      failures++;
      $display("FAIL flush_clean_block: got v=%b d=%0d expected v=1 d=10",
               out_valid, data_out);
    end
    cfg(3'd0, 1'b1);
    out_ready = 1'b0;
    send(16'sd9);
    @(negedge clock);
    pipeline_flush = 1'b1;
    @(posedge clock);
    #1;
    pipeline_flush = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'sd0) begin
      failures++;
      $display("FAIL flush_outreg: got v=%b d=%0d expected v=0 d=0",
               out_valid, data_out);
    end
  endtask

  task automatic test_clamp();
    cfg(3'd7, 1'b1);
    for (int i = 0; i < 15; i++)
      send(16'sd2);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clamp_early: got %b expected 0", out_valid);
    end
    send(16'sd18);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd3) begin
      failures++;
      $display("FAIL clamp_result: got v=%b d=%0d expected v=1 d=3",
               out_valid, data_out);
    end
  endtask

  task automatic test_async_reset();
    cfg(3'd2, 1'b0);
    out_ready = 1'b0;
    send(16'sd1);
    send(16'sd2);
    send(16'sd3);
    send(16'sd4);
    out_ready = 1'b1;
    send(16'sd5);
    send(16'sd6);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'sd4) begin
      failures++;
      $display("FAIL pre_reset_state: got v=%b d=%0d expected v=0 d=4",
               out_valid, data_out);
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'sd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got v=%b d=%0d r=%b expected v=0 d=0 r=1",
               out_valid, data_out, in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    send(16'sd7);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd7) begin
      failures++;
      $display("FAIL reset_cfg_default: got v=%b d=%0d expected v=1 d=7",
               out_valid, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_negative();
    test_decimate();
    test_backpressure();
    test_cfg_midblock();
    test_flush();
    test_clamp();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
